// File: rtl/global_mem_responder.sv
// global_mem_responder: round-robin arbiter serving core read/write requests against a single-port synchronous RAM
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   core_read_req/core_write_req    per-core level requests, held until the matching done pulse
//   core_addr/core_wdata            per-core address and write data, 32 bits per core
//   core_read_done/core_write_done  one-cycle completion pulses, at most one bit high
//   core_rdata                      read data broadcast to all cores, held until the next read
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM port, read data valid MEM_LATENCY cycles after mem_en
//   busy                            high whenever a transaction is in flight
module global_mem_responder #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CORES-1:0]    core_read_req,
  input  logic [NUM_CORES-1:0]    core_write_req,
  input  logic [32*NUM_CORES-1:0] core_addr,
  input  logic [32*NUM_CORES-1:0] core_wdata,
  output logic [NUM_CORES-1:0]    core_read_done,
  output logic [NUM_CORES-1:0]    core_write_done,
  output logic [31:0]             core_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  output logic                    busy
);
  localparam int GW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int CW = $clog2(MEM_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                r_state, w_next;
  logic [GW-1:0]         r_rr, r_grant, w_pick;
  logic                  r_wr, w_found;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_wdata, r_rdata;
  logic [CW-1:0]         r_cnt;
  logic [NUM_CORES-1:0]  w_req;
  assign w_req      = core_read_req | core_write_req;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign core_rdata = r_rdata;
  // Scan downwards so the requester closest to r_rr is the last one written and wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (w_req[(int'(r_rr) + k) % NUM_CORES]) begin
        w_found = 1'b1;
        w_pick  = GW'((int'(r_rr) + k) % NUM_CORES);
      end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_found ? ISSUE : IDLE;
      ISSUE:   w_next = r_wr ? DONE : WAIT;
      WAIT:    w_next = r_cnt == '0 ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
    busy            = r_state != IDLE;
    mem_en          = r_state == ISSUE;
    mem_we          = r_state == ISSUE && r_wr;
    core_read_done  = (r_state == DONE && !r_wr) ? NUM_CORES'(1) << r_grant : '0;
    core_write_done = (r_state == DONE && r_wr) ? NUM_CORES'(1) << r_grant : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_grant <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) begin
        r_grant <= w_pick;
        r_wr    <= !core_read_req[w_pick];
        r_addr  <= core_addr[32*int'(w_pick) +: ADDR_W];
        r_wdata <= core_wdata[32*int'(w_pick) +: 32];
        r_rr    <= GW'((int'(w_pick) + 1) % NUM_CORES);
      end
      if (r_state == ISSUE) r_cnt <= CW'(MEM_LATENCY - 1);
      // Counter reaching zero marks the cycle in which mem_rdata is valid.
      if (r_state == WAIT) begin
        if (r_cnt == '0) r_rdata <= mem_rdata;
        else r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_global_mem_responder.sv
// tb_global_mem_responder: randomized check of global_mem_responder against a transaction-level reference model
module tb_global_mem_responder;
  localparam int N = 4, AW = 8, L = 3, NCYC = 1600;
  logic clk = 1'b0, reset_n;
  logic [N-1:0] rreq, wreq, rdone, wdone;
  logic [32*N-1:0] caddr, cwdata;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  int total = 0, bad = 0;
  logic [31:0] ram [256];
  logic [31:0] pipe [L];
  logic [31:0] mmem [256];
  logic pr [N], pw [N];
  logic [31:0] pa [N], pd [N];
  int rr = 0, tg = 0, ag = 0, d = 0, fin = -1, ntx = 0, nrst = 0, op = 0;
  logic act = 1'b0, aw = 1'b0, fin_rd = 1'b0, rst_pend = 1'b0, burst;
  logic [AW-1:0] aaddr = '0;
  logic [31:0] awd = '0, exp_rdata = '0;

  always #5 clk = ~clk;

  global_mem_responder #(.NUM_CORES(N), .ADDR_W(AW), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_read_req(rreq), .core_write_req(wreq),
    .core_addr(caddr), .core_wdata(cwdata),
    .core_read_done(rdone), .core_write_done(wdone), .core_rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // RAM environment: read data emerges L cycles after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : $urandom;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[L-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string p);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_mem_en"}, 32'(mem_en), 0);
    chk({p, "_mem_we"}, 32'(mem_we), 0);
    chk({p, "_mem_addr"}, 32'(mem_addr), 0);
    chk({p, "_mem_wdata"}, mem_wdata, 0);
    chk({p, "_rdone"}, 32'(rdone), 0);
    chk({p, "_wdone"}, 32'(wdone), 0);
    chk({p, "_rdata"}, rdata, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    rreq = '0;
    wreq = '0;
    caddr = '0;
    cwdata = '0;
    for (int i = 0; i < N; i++) begin
      pr[i] = 1'b0;
      pw[i] = 1'b0;
      pa[i] = '0;
      pd[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      mmem[i] = $urandom;
      ram[i] <= mmem[i];
    end
    repeat (2) @(negedge clk);
    chk_quiet("rst");
    reset_n = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      burst = c >= 300 && c < 700;
      for (int i = 0; i < N; i++) begin
        if (fin == i) begin
          if (fin_rd) pr[i] = 1'b0;
          else pw[i] = 1'b0;
        end else if (!pr[i] && !pw[i] && (burst || $urandom_range(0, 3) == 0)) begin
          op = burst ? 0 : int'($urandom_range(0, 2));
          pr[i] = op != 1;
          pw[i] = op != 0;
          pa[i] = $urandom;
          pa[i][AW-1:0] = AW'($urandom_range(0, 7));
          pd[i] = $urandom;
        end
      end
      fin = -1;
      for (int i = 0; i < N; i++) begin
        rreq[i] = pr[i];
        wreq[i] = pw[i];
        caddr[32*i +: 32] = pa[i];
        cwdata[32*i +: 32] = pd[i];
      end
      @(negedge clk);
      if (rst_pend) begin
        reset_n = 1'b1;
        rst_pend = 1'b0;
      end
      d = act ? tg + (aw ? 2 : L + 2) : -1;
      chk("busy", 32'(busy), 32'(act && c > tg && c <= d));
      chk("mem_en", 32'(mem_en), 32'(act && c == tg + 1));
      chk("mem_we", 32'(mem_we), 32'(act && aw && c == tg + 1));
      if (act && c == tg + 1) begin
        chk("mem_addr", 32'(mem_addr), 32'(aaddr));
        if (aw) chk("mem_wdata", mem_wdata, awd);
      end
      if (act && !aw && c == d) exp_rdata = mmem[aaddr];
      chk("rdone", 32'(rdone), (act && !aw && c == d) ? 32'(1) << ag : 0);
      chk("wdone", 32'(wdone), (act && aw && c == d) ? 32'(1) << ag : 0);
      chk("rdata", rdata, exp_rdata);
      if (act && c == d) begin
        if (aw) mmem[aaddr] = awd;
        fin = ag;
        fin_rd = !aw;
        act = 1'b0;
        ntx++;
      end else if (act && !aw && c == tg + 3 && c >= 800 && nrst < 2) begin
        reset_n = 1'b0;
        #1;
        chk_quiet("arst");
        act = 1'b0;
        rr = 0;
        exp_rdata = '0;
        nrst++;
        rst_pend = 1'b1;
      end else if (!act) begin
        for (int k = 0; k < N && !act; k++) begin
          if (pr[(rr + k) % N] || pw[(rr + k) % N]) begin
            ag = (rr + k) % N;
            act = 1'b1;
            tg = c;
            aw = !pr[ag];
            aaddr = pa[ag][AW-1:0];
            awd = pd[ag];
          end
        end
        if (act) rr = (ag + 1) % N;
      end
    end
    chk("n_resets", nrst, 2);
    chk("txn_floor", 32'(ntx >= 100), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
